// File: rtl/n_bit1x4_demux_buffer.sv
// n_bit1x4_demux_buffer
// Registered 1-to-4 demultiplexer with valid/ready handshaking. A word on D
// is steered to the slot chosen by S, or to all four slots when BCAST=1.
// Each slot has a one-entry holding register, a valid flag and a saturating
// count of words loaded into it.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   D [n-1:0]      input word
//   S [1:0]        destination select (00=A, 01=B, 10=C, 11=D)
//   BCAST          write the word to all four slots, S ignored
//   in_valid       D/S/BCAST valid this cycle
//   in_ready       word is accepted this cycle (combinational)
//   YA..YD [n-1:0] held output words
//   vA..vD         slot holds a valid word
//   rA..rD         consumer takes the slot's word this cycle
//   cntA..cntD     words loaded into each slot, saturating at 8'hFF
//
// Per-slot state (held in the valid flag)
//   state | meaning
//   EMPTY | v=0, slot can take a word
//   FULL  | v=1, word waits for the consumer; reloads when drained same edge

module n_bit1x4_demux_buffer #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] D,
  input  logic [1:0]   S,
  input  logic         BCAST,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [n-1:0] YA,
  output logic [n-1:0] YB,
  output logic [n-1:0] YC,
  output logic [n-1:0] YD,
  output logic         vA,
  output logic         vB,
  output logic         vC,
  output logic         vD,
  input  logic         rA,
  input  logic         rB,
  input  logic         rC,
  input  logic         rD,
  output logic [7:0]   cntA,
  output logic [7:0]   cntB,
  output logic [7:0]   cntC,
  output logic [7:0]   cntD
);

  logic [n-1:0] y_q   [4];
  logic [7:0]   cnt_q [4];
  logic [3:0]   v_q;
  logic [3:0]   r;
  logic [3:0]   can_load;
  logic [3:0]   load;
  logic         accept;

  assign r = {rD, rC, rB, rA};

  // A slot can take a word when empty, or when its current word leaves on
  // the same edge.
  assign can_load = ~v_q | r;

  // Broadcast is all-or-nothing, so it needs every slot free at once.
  assign in_ready = BCAST ? (&can_load) : can_load[S];
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < 4; k++) begin : g_slot
    assign load[k] = accept & (BCAST | (S == 2'(k)));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        y_q[k]   <= '0;
        v_q[k]   <= 1'b0;
        cnt_q[k] <= '0;
      end else if (load[k]) begin
        y_q[k] <= D;
        v_q[k] <= 1'b1;
        if (cnt_q[k] != 8'hFF) cnt_q[k] <= cnt_q[k] + 8'd1;
      end else if (v_q[k] && r[k]) begin
        // Y is left as-is on drain; it is only meaningful while v=1.
        v_q[k] <= 1'b0;
      end
    end
  end

  assign YA   = y_q[0];
  assign YB   = y_q[1];
  assign YC   = y_q[2];
  assign YD   = y_q[3];
  assign vA   = v_q[0];
  assign vB   = v_q[1];
  assign vC   = v_q[2];
  assign vD   = v_q[3];
  assign cntA = cnt_q[0];
  assign cntB = cnt_q[1];
  assign cntC = cnt_q[2];
  assign cntD = cnt_q[3];

endmodule

// File: tb/tb_n_bit1x4_demux_buffer.sv
// Directed self-checking bench for n_bit1x4_demux_buffer (n=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_n_bit1x4_demux_buffer;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] D;
  logic [1:0]   S;
  logic         BCAST;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] YA, YB, YC, YD;
  logic         vA, vB, vC, vD;
  logic         rA, rB, rC, rD;
  logic [7:0]   cntA, cntB, cntC, cntD;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  n_bit1x4_demux_buffer #(.n(N)) dut (
    .clk(clk), .rst_n(rst_n), .D(D), .S(S), .BCAST(BCAST),
    .in_valid(in_valid), .in_ready(in_ready),
    .YA(YA), .YB(YB), .YC(YC), .YD(YD),
    .vA(vA), .vB(vB), .vC(vC), .vD(vD),
    .rA(rA), .rB(rB), .rC(rC), .rD(rD),
    .cntA(cntA), .cntB(cntB), .cntC(cntC), .cntD(cntD)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; D = '0; S = 2'd0; BCAST = 1'b0; in_valid = 1'b0;
    rA = 1'b0; rB = 1'b0; rC = 1'b0; rD = 1'b0;
    tick(); tick();
    chk("rst_v", {28'd0, vD, vC, vB, vA}, 32'd0);
    chk("rst_y", {16'd0, YD, YC, YB, YA}, 32'd0);
    chk("rst_cnt", {cntD, cntC, cntB, cntA}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", in_ready, 1);

    // Unicast to B
    D = 4'hA; S = 2'b01; in_valid = 1'b1;
    #1 chk("uni_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("uni_vB", vB, 1);
    chk("uni_YB", YB, 4'hA);
    chk("uni_cntB", cntB, 1);
    chk("uni_others_v", {vD, vC, vA}, 3'b000);
    S = 2'b00;
    #1 chk("uni_ready_A", in_ready, 1);

    // Backpressure on C
    S = 2'b10; D = 4'h3; in_valid = 1'b1;
    tick();
    chk("bp_load_YC", YC, 4'h3);
    chk("bp_load_cntC", cntC, 1);
    D = 4'h7;
    #1 chk("bp_ready0", in_ready, 0);
    tick();
    chk("bp_hold_YC", YC, 4'h3);
    chk("bp_hold_cntC", cntC, 1);
    rC = 1'b1;
    #1 chk("bp_ready1", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_swap_YC", YC, 4'h7);
    chk("bp_swap_vC", vC, 1);
    chk("bp_swap_cntC", cntC, 2);
    tick();
    chk("bp_drain_vC", vC, 0);
    rC = 1'b0;

    // Empty B, then fill D
    rB = 1'b1;
    tick();
    rB = 1'b0;
    chk("drain_vB", vB, 0);
    S = 2'b11; D = 4'h9; in_valid = 1'b1;
    tick();
    chk("fill_vD", vD, 1);
    chk("fill_cntD", cntD, 1);

    // Broadcast blocked by D
    BCAST = 1'b1; D = 4'h5; S = 2'b00;
    #1 chk("bc_ready0", in_ready, 0);
    tick();
    chk("bc_block_v", {vD, vC, vB, vA}, 4'b1000);
    chk("bc_block_YD", YD, 4'h9);
    chk("bc_block_cnt", {cntD, cntC, cntB, cntA}, {8'd1, 8'd2, 8'd1, 8'd0});
    rD = 1'b1;
    #1 chk("bc_ready1", in_ready, 1);
    tick();
    in_valid = 1'b0; BCAST = 1'b0; rD = 1'b0;
    chk("bc_v", {vD, vC, vB, vA}, 4'b1111);
    chk("bc_y", {YD, YC, YB, YA}, 16'h5555);
    chk("bc_cnt", {cntD, cntC, cntB, cntA}, {8'd2, 8'd3, 8'd2, 8'd1});

    // Select change while stalled
    S = 2'b00; D = 4'h6; in_valid = 1'b1; rD = 1'b1;
    #1 chk("sel_ready_A0", in_ready, 0);
    tick();
    rD = 1'b0;
    chk("sel_drain_vD", vD, 0);
    chk("sel_noload_cntA", cntA, 1);
    #1 chk("sel_still_A0", in_ready, 0);
    S = 2'b11;
    #1 chk("sel_ready_D1", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("sel_YD", YD, 4'h6);
    chk("sel_vD", vD, 1);
    chk("sel_cntD", cntD, 3);
    chk("sel_YA_hold", YA, 4'h5);
    chk("sel_cntA_hold", cntA, 1);

    // Streaming into A, cntA starts at 1 and saturates
    rA = 1'b1; S = 2'b00; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [7:0] exp_cnt;
      logic [31:0] iv;
      iv = i;
      D = iv[3:0];
      #1 chk("stream_ready", in_ready, 1);
      tick();
      exp_cnt = (i + 2 > 255) ? 8'd255 : 8'(i + 2);
      chk("stream_YA", YA, iv[3:0]);
      chk("stream_cntA", cntA, exp_cnt);
    end
    in_valid = 1'b0; rA = 1'b0;
    chk("stream_vA", vA, 1);
    chk("stream_others_cnt", {cntD, cntC, cntB}, {8'd3, 8'd3, 8'd2});

    // Reset mid-operation with a pending accept
    chk("pre_rst_v", {vD, vC, vB, vA}, 4'b1111);
    rst_n = 1'b0; in_valid = 1'b1; S = 2'b01; rB = 1'b1; D = 4'hF;
    tick();
    rst_n = 1'b1; in_valid = 1'b0; rB = 1'b0;
    chk("mrst_v", {vD, vC, vB, vA}, 4'b0000);
    chk("mrst_y", {YD, YC, YB, YA}, 16'h0000);
    chk("mrst_cnt", {cntD, cntC, cntB, cntA}, 32'd0);
    #1 chk("mrst_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/n_bit1x4_demux_buffer.md
# n_bit1x4_demux_buffer

Registered 1-to-4 demultiplexer with valid/ready handshaking. It steers an n-bit word arriving on one input channel to one of four output channels chosen by a 2-bit select, or to all four in broadcast mode. It is the distributing counterpart to the n-bit 4x1 multiplexer: together they let a datapath fan a stream out to four consumers and merge it back. Each output has a one-entry holding register and an accepted-word counter.

## Interface
- n, 4, data width in bits (n ≥ 1)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- D  in  n  input word
- S  in  2  destination select: 00→A, 01→B, 10→C, 11→D
- BCAST  in  1  1 = write the word to all four outputs, S ignored
- in_valid  in  1  D/S/BCAST valid this cycle
- in_ready  out  1  block accepts the word this cycle (combinational)
- YA, YB, YC, YD  out  n each  held output words
- vA, vB, vC, vD  out  1 each  output slot holds a valid word
- rA, rB, rC, rD  in  1 each  consumer takes the word this cycle
- cntA, cntB, cntC, cntD  out  8 each  words delivered into each slot, saturating

## Operation
- Per slot k ∈ {A,B,C,D}: data register Yk, flag vk, counter cntk.
- Drain: vk & rk at a rising edge → slot empties (vk←0) unless a load happens on the same edge.
- Can-load(k) = ~vk | rk. Drain and load on the same edge is allowed, giving one word per cycle per slot.
- in_ready = BCAST ? AND of can-load(k) over all four slots : can-load(S).
- Accept = in_valid & in_ready. On accept:
  - unicast: Y[S]←D, v[S]←1, cnt[S]←cnt[S]+1.
  - broadcast: all four Yk←D, vk←1, cntk←cntk+1.
- Broadcast is all-or-nothing. No partial write when any slot is blocked.
- Unselected slots hold Yk, vk and cntk. Their drains proceed independently.
- in_valid=0 → no load, and the counters hold.
- Counters saturate at 8'hFF, with no wrap.
- Yk is not cleared when the slot drains. Yk is meaningful only while vk=1.
- S and BCAST are sampled only on an accept edge. Changing them while in_valid=1 and in_ready=0 is legal; in_ready tracks the new select combinationally.
- No internal state machine beyond the per-slot full/empty flag: state EMPTY (vk=0) and FULL (vk=1).
  - EMPTY→FULL on load.
  - FULL→EMPTY on drain without load.
  - FULL→FULL on drain+load, or on no drain.

## Timing
- Reset (rst_n=0 at a rising edge) sets every output to zero: all Yk=0, vk=0, cntk=0.
- in_ready has no reset value of its own. It is the combinational result of the equation above, which gives 1 after reset because all slots are empty. While rst_n=0 its value is a don't-care, and no accept is performed.
- Reset wins over any simultaneous accept or drain. Words held or in flight are discarded.
- Latency: a word accepted at edge t appears on Yk with vk=1 immediately after edge t (1-cycle register latency).
- Throughput: one accept per cycle when the target consumer holds rk=1 continuously.
- in_ready depends combinationally on rk, S, BCAST and vk. There is no combinational path from D to any output.
- The consumer must keep rk stable relative to clk. rk while vk=0 is ignored.

## Test plan
- Reset then unicast: n=4, after reset drive D=4'hA, S=01, in_valid=1 for one cycle, with all r=0 → next cycle vB=1, YB=4'hA, cntB=1. vA, vC and vD stay 0, and in_ready stays 1 for S=00.
- Backpressure: slot C full, rC=0, S=10, in_valid=1 → in_ready=0 and YC and cntC hold. Raise rC → same edge drains the old word and loads the new one, vC stays 1, cntC+1.
- Broadcast blocked: vD=1, rD=0, BCAST=1 → in_ready=0 and no slot changes. Set rD=1 → D=4'h5 lands in all four slots, and every cnt increments by 1.
- Streaming: rA=1 held, S=00, 300 consecutive accepts of an incrementing D → YA follows D with 1-cycle lag, and cntA saturates at 255 with no wrap.
- Reset mid-operation: all slots full, rst_n=0 for one edge with in_valid=1 → all vk=0, Yk=0, cntk=0, and no word is accepted.
- Select change while stalled: S=00 with slot A blocked (in_ready=0), switch S to 11 with slot D empty → in_ready=1 in the same cycle, and the word goes only to D.
